// File: rtl/visitor_center.sv
`default_nettype none
// ============================================================================
// Module   : visitor_center
// Brief    : Source end of a neighborhood visitor interface. Stores every
//            body (x, y, mass) written by the HPS and streams one visitor
//            per neighborhood sweep, advancing on each next pulse.
// Revision : 1.0 - initial release
// ============================================================================
module visitor_center #(
    parameter int MAX_M10K_SIZE    = 4096,
    parameter int M10K_ADDRESS_LEN = 12
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        filling,
    input  logic [M10K_ADDRESS_LEN-1:0] pos_write_addr,
    input  logic                        pos_we,
    input  logic [31:0]                 x_pos_write_data_in,
    input  logic [31:0]                 y_pos_write_data_in,
    input  logic [31:0]                 mass_write_data_in,
    input  logic [M10K_ADDRESS_LEN-1:0] total_max_index,
    input  logic [M10K_ADDRESS_LEN-1:0] town_base,
    input  logic [M10K_ADDRESS_LEN-1:0] town_max_index,
    input  logic                        next,
    output logic [31:0]                 visitor_x_pos,
    output logic [31:0]                 visitor_y_pos,
    output logic [31:0]                 visitor_mass,
    output logic                        relative_visitor_valid,
    output logic [M10K_ADDRESS_LEN-1:0] relative_visitor_index,
    output logic                        visitor_done
);

    localparam int                        AW       = M10K_ADDRESS_LEN;
    localparam logic [AW-1:0]             IDX_ZERO = '0;
    localparam logic [AW-1:0]             IDX_ONE  = {{(AW-1){1'b0}}, 1'b1};
    localparam logic [AW-1:0]             IDX_TWO  = {{(AW-2){1'b0}}, 2'b10};

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FILL  = 2'd1,
        ST_RUN   = 2'd2,
        ST_DRAIN = 2'd3
    } state_t;

    state_t          state_q;

    // Body storage: port B written by the HPS, port A read by the sweep
    logic [31:0]     x_mem [MAX_M10K_SIZE];
    logic [31:0]     y_mem [MAX_M10K_SIZE];
    logic [31:0]     m_mem [MAX_M10K_SIZE];

    logic [AW-1:0]   rd_addr_q;
    logic [31:0]     x_rd_q, y_rd_q, m_rd_q;

    // Two-stage markers tracking read data, visitor advance and last-visitor retire
    logic            rd_p1_q, rd_p2_q;
    logic            adv_p1_q, adv_p2_q;
    logic            last_p1_q, last_p2_q;

    logic [31:0]     stg_x_q, stg_y_q, stg_m_q;
    logic            stg_valid_q;

    logic [AW-1:0]   vis_idx_q;
    logic [31:0]     vis_x_q, vis_y_q, vis_m_q;
    logic            done_q;

    logic [AW-1:0]   rel_off;

    // HPS write port: honoured in every state
    always_ff @(posedge clk) begin
        if (pos_we) begin
            x_mem[pos_write_addr] <= x_pos_write_data_in;
            y_mem[pos_write_addr] <= y_pos_write_data_in;
            m_mem[pos_write_addr] <= mass_write_data_in;
        end
    end

    // Read port: registered memory output, one cycle after the address register
    always_ff @(posedge clk) begin
        x_rd_q <= x_mem[rd_addr_q];
        y_rd_q <= y_mem[rd_addr_q];
        m_rd_q <= m_mem[rd_addr_q];
    end

    // Sweep control: state, snooping, staging refill and delayed visitor load
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            rd_addr_q   <= '0;
            rd_p1_q     <= 1'b0;
            rd_p2_q     <= 1'b0;
            adv_p1_q    <= 1'b0;
            adv_p2_q    <= 1'b0;
            last_p1_q   <= 1'b0;
            last_p2_q   <= 1'b0;
            stg_x_q     <= '0;
            stg_y_q     <= '0;
            stg_m_q     <= '0;
            stg_valid_q <= 1'b0;
            vis_idx_q   <= '0;
            vis_x_q     <= '0;
            vis_y_q     <= '0;
            vis_m_q     <= '0;
            done_q      <= 1'b0;
        end else begin
            rd_p1_q   <= 1'b0;
            rd_p2_q   <= rd_p1_q;
            adv_p1_q  <= 1'b0;
            adv_p2_q  <= adv_p1_q;
            last_p1_q <= 1'b0;
            last_p2_q <= last_p1_q;

            // Two cycles after an advance: present the staged body and fetch the one after it
            if (adv_p2_q) begin
                if (stg_valid_q) begin
                    vis_x_q <= stg_x_q;
                    vis_y_q <= stg_y_q;
                    vis_m_q <= stg_m_q;
                end
                stg_valid_q <= 1'b0;
                if (vis_idx_q < total_max_index) begin
                    rd_addr_q <= vis_idx_q + IDX_ONE;
                    rd_p1_q   <= 1'b1;
                end
            end

            if (rd_p2_q) begin
                stg_x_q     <= x_rd_q;
                stg_y_q     <= y_rd_q;
                stg_m_q     <= m_rd_q;
                stg_valid_q <= 1'b1;
            end

            // The retired last visitor contributes no mass during the drain sweep
            if (last_p2_q) begin
                vis_m_q <= '0;
            end

            case (state_q)
                ST_IDLE: begin
                    if (filling) begin
                        state_q     <= ST_FILL;
                        done_q      <= 1'b0;
                        stg_valid_q <= 1'b0;
                    end
                end
                ST_FILL: begin
                    if (pos_we && pos_write_addr == IDX_ZERO) begin
                        vis_x_q <= x_pos_write_data_in;
                        vis_y_q <= y_pos_write_data_in;
                        vis_m_q <= mass_write_data_in;
                    end
                    if (pos_we && pos_write_addr == IDX_ONE) begin
                        stg_x_q     <= x_pos_write_data_in;
                        stg_y_q     <= y_pos_write_data_in;
                        stg_m_q     <= mass_write_data_in;
                        stg_valid_q <= 1'b1;
                    end
                    if (!filling) begin
                        state_q   <= ST_RUN;
                        vis_idx_q <= '0;
                        // Staging already holds body 1 from the snoop; this
                        // primes the read port with body 2.
                        if (total_max_index >= IDX_TWO) begin
                            rd_addr_q <= IDX_TWO;
                        end
                    end
                end
                ST_RUN: begin
                    if (filling) begin
                        state_q     <= ST_FILL;
                        done_q      <= 1'b0;
                        stg_valid_q <= 1'b0;
                        rd_p1_q     <= 1'b0;
                        rd_p2_q     <= 1'b0;
                        adv_p2_q    <= 1'b0;
                        last_p2_q   <= 1'b0;
                    end else if (next) begin
                        if (vis_idx_q == total_max_index) begin
                            state_q   <= ST_DRAIN;
                            done_q    <= 1'b1;
                            last_p1_q <= 1'b1;
                        end else begin
                            vis_idx_q <= vis_idx_q + IDX_ONE;
                            adv_p1_q  <= 1'b1;
                        end
                    end
                end
                ST_DRAIN: begin
                    if (filling) begin
                        state_q     <= ST_FILL;
                        done_q      <= 1'b0;
                        stg_valid_q <= 1'b0;
                        rd_p1_q     <= 1'b0;
                        rd_p2_q     <= 1'b0;
                        adv_p2_q    <= 1'b0;
                        last_p2_q   <= 1'b0;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    // Relative index of the active visitor within this town
    always_comb begin
        rel_off = vis_idx_q - town_base;
    end

    assign relative_visitor_index = rel_off;
    assign relative_visitor_valid = (state_q == ST_RUN) && !done_q &&
                                    (vis_idx_q >= town_base) &&
                                    (rel_off <= town_max_index);
    assign visitor_x_pos          = vis_x_q;
    assign visitor_y_pos          = vis_y_q;
    assign visitor_mass           = vis_m_q;
    assign visitor_done           = done_q;

endmodule
`default_nettype wire

// File: tb/tb_visitor_center.sv
`default_nettype none
// ============================================================================
// Module   : tb_visitor_center
// Brief    : Scoreboard bench for visitor_center. Stimulus pushes expected
//            visitor state with the cycle it must appear; a monitor pops and
//            compares on the falling edge.
// Revision : 1.0 - initial release
// ============================================================================
module tb_visitor_center;

    logic        clk = 1'b0;
    logic        reset, filling, pos_we, next;
    logic [11:0] pos_write_addr, total_max_index, town_base, town_max_index;
    logic [31:0] x_in, y_in, m_in;
    logic [31:0] visitor_x_pos, visitor_y_pos, visitor_mass;
    logic        relative_visitor_valid, visitor_done;
    logic [11:0] relative_visitor_index;

    always #5 clk = ~clk;

    visitor_center dut (
        .clk                    (clk),
        .reset                  (reset),
        .filling                (filling),
        .pos_write_addr         (pos_write_addr),
        .pos_we                 (pos_we),
        .x_pos_write_data_in    (x_in),
        .y_pos_write_data_in    (y_in),
        .mass_write_data_in     (m_in),
        .total_max_index        (total_max_index),
        .town_base              (town_base),
        .town_max_index         (town_max_index),
        .next                   (next),
        .visitor_x_pos          (visitor_x_pos),
        .visitor_y_pos          (visitor_y_pos),
        .visitor_mass           (visitor_mass),
        .relative_visitor_valid (relative_visitor_valid),
        .relative_visitor_index (relative_visitor_index),
        .visitor_done           (visitor_done)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          due;
        string       name;
        bit          chk_data;
        bit          chk_rel;
        logic [31:0] x, y, m;
        logic        valid;
        logic [11:0] rel;
        logic        done;
    } exp_t;

    exp_t        sb[$];
    exp_t        mon_e;
    int          total_n = 0;
    int          bad_n   = 0;
    logic [31:0] bx[16], by[16], bm[16];
    int          cur_base, cur_tmax;

    // Reference: a body index belongs to the town when it falls in [base, base+tmax]
    function automatic bit in_town(input int idx);
        return (idx >= cur_base) && ((idx - cur_base) <= cur_tmax);
    endfunction

    function automatic logic [11:0] rel_of(input int idx);
        int r;
        r = idx - cur_base;
        return r[11:0];
    endfunction

    task automatic push(input int due, input string nm, input bit chkd, input bit chkr,
                        input logic [31:0] x, input logic [31:0] y, input logic [31:0] m,
                        input logic v, input logic [11:0] r, input logic d);
        exp_t e;
        e.due = due; e.name = nm; e.chk_data = chkd; e.chk_rel = chkr;
        e.x = x; e.y = y; e.m = m; e.valid = v; e.rel = r; e.done = d;
        sb.push_back(e);
    endtask

    task automatic cmp(input string nm, input string f, input logic [31:0] a, input logic [31:0] e);
        total_n++;
        if (a !== e) begin
            bad_n++;
            $display("FAIL %s.%s at cycle %0d: got=%h want=%h", nm, f, cyc, a, e);
        end
    endtask

    // Monitor: compare every entry whose cycle has arrived
    always @(negedge clk) begin
        while (sb.size() > 0 && sb[0].due <= cyc) begin
            mon_e = sb.pop_front();
            if (mon_e.due < cyc) begin
                total_n++;
                bad_n++;
                $display("FAIL %s: check for cycle %0d missed (now %0d)", mon_e.name, mon_e.due, cyc);
            end else begin
                if (mon_e.chk_data) begin
                    cmp(mon_e.name, "x", visitor_x_pos, mon_e.x);
                    cmp(mon_e.name, "y", visitor_y_pos, mon_e.y);
                    cmp(mon_e.name, "mass", visitor_mass, mon_e.m);
                end
                cmp(mon_e.name, "valid", {31'd0, relative_visitor_valid}, {31'd0, mon_e.valid});
                if (mon_e.chk_rel)
                    cmp(mon_e.name, "rel", {20'd0, relative_visitor_index}, {20'd0, mon_e.rel});
                cmp(mon_e.name, "done", {31'd0, visitor_done}, {31'd0, mon_e.done});
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic rand_bodies(input int n);
        for (int i = 0; i < n; i++) begin
            bx[i] = $urandom;
            by[i] = $urandom;
            bm[i] = $urandom;
        end
    endtask

    task automatic pulse_next(output int t);
        next = 1'b1;
        tick();
        t    = cyc;
        next = 1'b0;
    endtask

    task automatic wait_gap();
        int g;
        g = $urandom_range(5, 8);
        repeat (g - 1) tick();
    endtask

    // Fill n bodies, start the frame and step visitors (stop after stop_at steps if >= 0)
    task automatic do_run(input int n, input int base, input int tmax, input int stop_at);
        int t;
        cur_base        = base;
        cur_tmax        = tmax;
        total_max_index = 12'(n - 1);
        town_base       = 12'(base);
        town_max_index  = 12'(tmax);
        filling         = 1'b1;
        tick();
        push(cyc, "fill_enter", 0, 0, 0, 0, 0, 1'b0, 12'd0, 1'b0);
        for (int a = 0; a < n; a++) begin
            pos_we = 1'b1; pos_write_addr = 12'(a);
            x_in = bx[a]; y_in = by[a]; m_in = bm[a];
            tick();
        end
        pos_we  = 1'b0;
        filling = 1'b0;
        tick();
        push(cyc, "run_start", 1, in_town(0), bx[0], by[0], bm[0], in_town(0), rel_of(0), 1'b0);
        for (int k = 0; k < n; k++) begin
            if (k == stop_at) return;
            wait_gap();
            pulse_next(t);
            if (k < n - 1) begin
                push(t,     "adv_idx",  1, in_town(k + 1), bx[k], by[k], bm[k], in_town(k + 1), rel_of(k + 1), 1'b0);
                push(t + 1, "adv_hold", 1, 0, bx[k], by[k], bm[k], in_town(k + 1), 12'd0, 1'b0);
                push(t + 2, "adv_load", 1, 0, bx[k + 1], by[k + 1], bm[k + 1], in_town(k + 1), 12'd0, 1'b0);
            end else begin
                push(t,     "last",      1, 0, bx[k], by[k], bm[k], 1'b0, 12'd0, 1'b1);
                push(t + 1, "last_hold", 1, 0, bx[k], by[k], bm[k], 1'b0, 12'd0, 1'b1);
                push(t + 2, "last_zero", 1, 0, bx[k], by[k], 32'd0, 1'b0, 12'd0, 1'b1);
            end
        end
        wait_gap();
        pulse_next(t);
        push(t,     "drain_next", 1, 0, bx[n - 1], by[n - 1], 32'd0, 1'b0, 12'd0, 1'b1);
        push(t + 3, "drain_hold", 1, 0, bx[n - 1], by[n - 1], 32'd0, 1'b0, 12'd0, 1'b1);
        repeat (5) tick();
    endtask

    task automatic scen1_bodies();
        rand_bodies(8);
        bx[0] = 32'd1; by[0] = 32'd2; bm[0] = 32'd3;
        bx[1] = 32'd4; by[1] = 32'd5; bm[1] = 32'd6;
    endtask

    initial begin
        reset = 1'b1; filling = 1'b0; pos_we = 1'b0; next = 1'b0;
        pos_write_addr = '0; total_max_index = '0; town_base = '0; town_max_index = '0;
        x_in = '0; y_in = '0; m_in = '0;
        cur_base = 0; cur_tmax = 0;
        repeat (3) tick();
        reset = 1'b0;
        push(cyc, "reset", 1, 1, 0, 0, 0, 1'b0, 12'd0, 1'b0);
        // next outside RUN must be ignored
        next = 1'b1; tick(); next = 1'b0;
        push(cyc, "idle_next", 1, 1, 0, 0, 0, 1'b0, 12'd0, 1'b0);
        repeat (2) tick();

        scen1_bodies();
        do_run(8, 0, 7, -1);

        rand_bodies(8);
        do_run(8, 4, 3, -1);

        // Reset mid-run while visitor 5 is active
        rand_bodies(8);
        do_run(8, 0, 7, 5);
        repeat (4) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        push(cyc, "mid_reset", 1, 1, 0, 0, 0, 1'b0, 12'd0, 1'b0);
        repeat (2) tick();
        scen1_bodies();
        do_run(8, 0, 7, -1);

        rand_bodies(2);
        do_run(2, 0, 7, -1);

        repeat (4) begin
            int n, base;
            n    = $urandom_range(3, 16);
            base = $urandom_range(0, n - 1);
            rand_bodies(n);
            do_run(n, base, $urandom_range(4, 9), -1);
        end

        for (int i = 0; i < 200 && sb.size() > 0; i++) tick();
        if (sb.size() > 0) begin
            total_n++;
            bad_n++;
            $display("FAIL drain_queue: %0d checks never reached", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total_n, bad_n);
        $finish;
    end

endmodule
`default_nettype wire
